// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MD_DIV_EN to build the restoring divider; without it DIV/DIVU starts are ignored.
module md_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] mt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] a, mag_a, mag_b;
  logic [2*DATA_W-1:0] p, p_nx, res;
  logic [DATA_W:0] sum;
  logic neg_q, sa, sb, go;
`ifdef MD_DIV_EN
  logic [DATA_W-1:0] b, r_nx;
  logic [DATA_W:0] t;
  logic div, neg_r, dz, borrow;
  assign go = start && state == IDLE;
`else
  assign go = start && state == IDLE && !op[1];
`endif
  assign sa = !op[0] && rs_data[DATA_W-1];
  assign sb = !op[0] && rt_data[DATA_W-1];
  assign mag_a = sa ? -rs_data : rs_data;
  assign mag_b = sb ? -rt_data : rt_data;
  always_comb begin
    state_nx = state == IDLE ? (go ? CALC : IDLE) :
               state == CALC ? (cnt == CW'(DATA_W-1) ? FIX : CALC) : IDLE;
    sum = {1'b0, p[2*DATA_W-1:DATA_W]} + {1'b0, p[0] ? a : {DATA_W{1'b0}}};
    p_nx = {sum, p[DATA_W-1:1]};
    res = neg_q ? -p : p;
`ifdef MD_DIV_EN
    t = p[2*DATA_W-1:DATA_W-1];
    borrow = t < {1'b0, b};
    r_nx = t[DATA_W-1:0] - b;
    if (div) begin
      p_nx = {borrow ? t[DATA_W-1:0] : r_nx, p[DATA_W-2:0], !borrow};
      // divide-by-zero keeps the raw dividend, so a holds rs_data for divides
      res = dz ? {a, {DATA_W{1'b1}}} :
            {neg_r ? -p[2*DATA_W-1:DATA_W] : p[2*DATA_W-1:DATA_W],
             neg_q ? -p[DATA_W-1:0] : p[DATA_W-1:0]};
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      busy <= state_nx != IDLE;
      done <= state == FIX;
      cnt <= state == CALC ? cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      p <= '0;
      neg_q <= 1'b0;
      hi <= '0;
      lo <= '0;
`ifdef MD_DIV_EN
      b <= '0;
      div <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
`endif
    end else begin
      if (go) begin
        a <= op[1] ? rs_data : mag_a;
        p <= {{DATA_W{1'b0}}, op[1] ? mag_a : mag_b};
        neg_q <= sa ^ sb;
`ifdef MD_DIV_EN
        b <= mag_b;
        div <= op[1];
        neg_r <= sa;
        dz <= rt_data == '0;
`endif
      end else if (state == CALC) begin
        p <= p_nx;
      end
      if (state == FIX) begin
        hi <= res[2*DATA_W-1:DATA_W];
        lo <= res[DATA_W-1:0];
      end else if (state == IDLE && !start) begin
        if (mthi) hi <= mt_data;
        if (mtlo) lo <= mt_data;
      end
    end
  end
endmodule
